// File: rtl/fft_pipe_sequencer_pkg.sv
// Shared constants and latency helpers for the FFT pipeline frame sequencer.
package fft_pipe_sequencer_pkg;

    // Tag carried alongside every beat through the pipeline delay line.
    localparam int TAG_W     = 4;
    localparam int TAG_V     = 0;
    localparam int TAG_SOF   = 1;
    localparam int TAG_EOF   = 2;
    localparam int TAG_ABORT = 3;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Smallest r with 2^r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Input-to-output latency of the whole pipeline: every butterfly plus
    // the sum of commutator depths 2^0 .. 2^(nstage-1).
    function automatic int total_lat(input int nstage, input int bf_lat);
        return (nstage + 1) * bf_lat + (1 << nstage) - 1;
    endfunction

    // Cycle at which a beat reaches commutator k: k+1 butterflies plus the
    // depths of commutators 0 .. k-1.
    function automatic int stage_off(input int k, input int bf_lat);
        return (k + 1) * bf_lat + (1 << k) - 1;
    endfunction

endpackage

// File: rtl/fft_pipe_sequencer_seq_tag_delay.sv
// Tag delay line mirroring pipeline latency, with per-commutator sof taps.
module seq_tag_delay
    import fft_pipe_sequencer_pkg::*;
#(
    parameter int LEN    = 25,
    parameter int NSTAGE = 4,
    parameter int BF_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tag_t              tag_i,
    output tag_t              tag_o,
    output logic [NSTAGE-1:0] sof_tap_o
);

    // sr_q[j] holds the tag injected j cycles ago.
    logic [LEN:1][TAG_W-1:0] sr_q;

    // Shift one position every cycle; reset flushes all in-flight tags.
    always_ff @(posedge clk_i) begin
        if (rst_i) sr_q <= '0;
        else       sr_q <= {sr_q[LEN-1:1], tag_i};
    end

    assign tag_o = sr_q[LEN];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_tap
        localparam int OFF = stage_off(k, BF_LAT);
        assign sof_tap_o[k] = sr_q[OFF][TAG_SOF];
    end

endmodule

// File: rtl/fft_pipe_sequencer.sv
// Frame controller for the streaming 4-lane FFT: framing, commutator starts,
// done-echo checking and output-aligned frame markers.
module fft_pipe_sequencer
    import fft_pipe_sequencer_pkg::*;
#(
    parameter int NBEATS = 16,
    parameter int NSTAGE = 4,
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [NSTAGE-1:0] stage_start,
    input  logic [NSTAGE-1:0] stage_done,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_abort,
    output logic              sync_err,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W = (clog2(NBEATS) < 1) ? 1 : clog2(NBEATS);
    localparam int LEN   = total_lat(NSTAGE, BF_LAT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    tag_t              tag_inj, tag_out;
    logic [NSTAGE-1:0] done_bad;
    logic              sync_err_q;
    logic [15:0]       frame_cnt_q;

    // The pipeline never stalls.
    assign in_ready = 1'b1;

    // Decode the incoming beat into a tag and the next framing state.
    // Any sof seen while a frame is open truncates it: abort rides on the
    // same tag as the new sof.
    always_comb begin
        tag_inj = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    tag_inj[TAG_V]   = 1'b1;
                    tag_inj[TAG_SOF] = 1'b1;
                    state_d          = ST_RUN;
                    cnt_d            = CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!in_valid) begin
                    tag_inj[TAG_ABORT] = 1'b1;
                    state_d            = ST_IDLE;
                    cnt_d              = '0;
                end else if (in_sof) begin
                    tag_inj[TAG_V]     = 1'b1;
                    tag_inj[TAG_SOF]   = 1'b1;
                    tag_inj[TAG_ABORT] = 1'b1;
                    cnt_d              = CNT_W'(1);
                end else begin
                    tag_inj[TAG_V] = 1'b1;
                    if (cnt_q == LAST) begin
                        tag_inj[TAG_EOF] = 1'b1;
                        state_d          = ST_IDLE;
                        cnt_d            = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Framing state and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_tag_delay #(
        .LEN    (LEN),
        .NSTAGE (NSTAGE),
        .BF_LAT (BF_LAT)
    ) u_delay (
        .clk_i     (clk),
        .rst_i     (reset),
        .tag_i     (tag_inj),
        .tag_o     (tag_out),
        .sof_tap_o (stage_start)
    );

    assign out_valid = tag_out[TAG_V];
    assign out_sof   = tag_out[TAG_SOF];
    assign out_eof   = tag_out[TAG_EOF];
    assign out_abort = tag_out[TAG_ABORT];

    // Each commutator must echo done exactly two cycles after its start.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_chk
        logic [1:0] exp_q;
        // Two-deep history of this stage's start pulse.
        always_ff @(posedge clk) begin
            if (reset) exp_q <= '0;
            else       exp_q <= {exp_q[0], stage_start[k]};
        end
        assign done_bad[k] = stage_done[k] ^ exp_q[1];
    end

    // Sticky sync error and completed-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sync_err_q <= sync_err_q | (|done_bad);
            if (out_eof) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_pipe_sequencer.sv
// Self-checking bench for fft_pipe_sequencer: directed scenarios then random
// traffic, all compared each cycle against a frame-level reference model.
module tb_fft_pipe_sequencer;

    localparam int NBEATS = 16;
    localparam int NSTAGE = 4;
    localparam int BF_LAT = 2;
    localparam int TOTAL  = (NSTAGE + 1) * BF_LAT + (1 << NSTAGE) - 1;
    localparam int NCYC   = 3000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic              in_ready;
    logic [NSTAGE-1:0] stage_start;
    logic [NSTAGE-1:0] done_drv = '0;
    logic              out_valid, out_sof, out_eof, out_abort, sync_err;
    logic [15:0]       frame_cnt;

    fft_pipe_sequencer #(
        .NBEATS (NBEATS),
        .NSTAGE (NSTAGE),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .stage_start (stage_start),
        .stage_done  (done_drv),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_abort   (out_abort),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: tag injected in each cycle as {abort,eof,sof,v}; everything
    // downstream is that history viewed through fixed latencies.
    logic [3:0]  inj [0:NCYC];
    bit          m_run;
    int          m_pos;
    logic [15:0] m_fc;
    bit          m_serr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int off(input int k);
        return (k + 1) * BF_LAT + (1 << k) - 1;
    endfunction

    function automatic logic [3:0] exp_tag(input int t);
        if (t < TOTAL) return 4'b0;
        return inj[t - TOTAL];
    endfunction

    function automatic logic exp_st(input int k, input int t);
        logic [3:0] g;
        if (t < off(k)) return 1'b0;
        g = inj[t - off(k)];
        return g[1];
    endfunction

    // Choose this cycle's inputs: directed scenarios first, then random.
    task automatic drive();
        bit rv, v, s, fault2;
        rv = (cyc < 3) || (cyc == 330);
        v  = 1'b0;
        s  = 1'b0;
        if (cyc == 5) v = 1'b1;
        else if (cyc >= 10 && cyc <= 25) begin v = 1'b1; s = (cyc == 10); end
        else if (cyc >= 60 && cyc <= 107) begin v = 1'b1; s = ((cyc - 60) % 16 == 0); end
        else if ((cyc >= 150 && cyc <= 154) || (cyc >= 160 && cyc <= 175)) begin
            v = 1'b1; s = (cyc == 150 || cyc == 160);
        end
        else if (cyc >= 200 && cyc <= 223) begin v = 1'b1; s = (cyc == 200 || cyc == 208); end
        else if (cyc >= 260 && cyc <= 275) begin v = 1'b1; s = (cyc == 260); end
        else if ((cyc >= 325 && cyc <= 330) || (cyc >= 340 && cyc <= 355)) begin
            v = 1'b1; s = (cyc == 325 || cyc == 340);
        end
        else if (cyc >= 400 && cyc < NCYC - 60) begin
            v  = ($urandom % 12 != 0);
            s  = ($urandom % 24 == 0) || (!m_run && ($urandom % 3 == 0));
            rv = ($urandom % 400 == 0);
        end
        fault2 = (cyc >= 250 && cyc <= 310);
        for (int k = 0; k < NSTAGE; k++) begin
            done_drv[k] = exp_st(k, (k == 2 && fault2) ? cyc - 3 : cyc - 2);
            if (cyc >= 400 && cyc < NCYC - 60 && ($urandom % 1500 == 0))
                done_drv[k] = ~done_drv[k];
        end
        reset    = rv;
        in_valid = v;
        in_sof   = s;
    endtask

    // Advance the model by one cycle of input.
    task automatic model();
        logic [3:0] t, o;
        t = 4'b0;
        if (reset) begin
            for (int i = (cyc > 40 ? cyc - 40 : 0); i <= cyc; i++) inj[i] = 4'b0;
            m_run  = 1'b0;
            m_pos  = 0;
            m_fc   = '0;
            m_serr = 1'b0;
        end else begin
            for (int k = 0; k < NSTAGE; k++)
                if (done_drv[k] !== exp_st(k, cyc - 2)) m_serr = 1'b1;
            o = exp_tag(cyc);
            if (o[2]) m_fc = m_fc + 16'd1;
            if (!in_valid) begin
                if (m_run) t = 4'b1000;
                m_run = 1'b0;
                m_pos = 0;
            end else if (in_sof) begin
                t     = m_run ? 4'b1011 : 4'b0011;
                m_run = 1'b1;
                m_pos = 1;
            end else if (m_run) begin
                t = 4'b0001;
                if (m_pos == NBEATS - 1) begin
                    t     = 4'b0101;
                    m_run = 1'b0;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            inj[cyc] = t;
        end
    endtask

    // Compare DUT outputs for the current cycle.
    task automatic check();
        logic [NSTAGE-1:0] es;
        for (int k = 0; k < NSTAGE; k++) es[k] = exp_st(k, cyc);
        chk("tag",   {out_abort, out_eof, out_sof, out_valid}, exp_tag(cyc));
        chk("start", stage_start, es);
        chk("ready", in_ready, 1);
        chk("serr",  sync_err, m_serr);
        chk("fcnt",  frame_cnt, m_fc);
        case (cyc)
            3:   chk("rst_tag", {out_abort, out_eof, out_sof, out_valid}, 0);
            12:  chk("st0@12", stage_start, 4'b0001);
            15:  chk("st1@15", stage_start, 4'b0010);
            19:  chk("st2@19", stage_start, 4'b0100);
            25:  chk("st3@25", stage_start, 4'b1000);
            35:  chk("sof@35", out_sof, 1);
            50:  chk("eof@50", out_eof, 1);
            51:  chk("fcnt@51", frame_cnt, 1);
            133: chk("fcnt@133", frame_cnt, 4);
            180: chk("abort@180", {out_abort, out_eof, out_valid}, 3'b100);
            185: chk("sof@185", out_sof, 1);
            233: chk("abortsof@233", {out_abort, out_sof}, 2'b11);
            248: chk("eof@248", out_eof, 1);
            271: chk("serr@271", sync_err, 0);
            272: chk("serr@272", sync_err, 1);
            320: chk("serr@320", sync_err, 1);
            331: chk("rst@331", {sync_err, frame_cnt}, 0);
            365: chk("sof@365", out_sof, 1);
            default: ;
        endcase
    endtask

    initial begin
        m_run  = 1'b0;
        m_pos  = 0;
        m_fc   = '0;
        m_serr = 1'b0;
        for (int i = 0; i <= NCYC; i++) inj[i] = 4'b0;
        while (cyc < NCYC) begin
            drive();
            model();
            @(posedge clk);
            #1;
            cyc++;
            check();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_pipe_sequencer.md
Name: fft_pipe_sequencer

Overview:
- Frame-level controller for the streaming 4-lane FFT pipeline: NSTAGE butterfly stages, each followed by a commutator of depth 2^k.
- Accepts input frames on a valid/sof handshake and counts beats.
- Issues a start pulse to each commutator, time-aligned to the first beat of every frame as that beat reaches the commutator.
- Checks each commutator's done echo, and produces out_valid/out_sof/out_eof/out_abort aligned to the pipeline output.

Parameters:
NBEATS, 16, beats per frame (N-point / 4 lanes); power of two, >= 2^NSTAGE
NSTAGE, 4, number of butterfly+commutator stages; commutator k has depth 2^k
BF_LAT, 2, butterfly latency in cycles (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat present
in_sof  in  1  first beat of frame (qualified by in_valid)
in_ready  out  1  sequencer accepts beats
stage_start  out  NSTAGE  one-cycle start pulse per commutator, bit k -> stage k
stage_done  in  NSTAGE  done echo from each commutator
out_valid  out  1  pipeline output beat valid
out_sof  out  1  first output beat of frame
out_eof  out  1  last output beat of a complete frame
out_abort  out  1  one-cycle pulse: the frame currently emerging was truncated
sync_err  out  1  sticky: a stage_done mismatch was seen; cleared only by reset
frame_cnt  out  16  completed frames emitted (wraps at 65535 -> 0)

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0 except in_ready=1.
  - beat counter 0, state IDLE, delay line cleared.
  - A reset mid-frame discards all in-flight tags; no out_eof or out_abort is generated for that frame.
- Input states: IDLE, RUN.
  - IDLE: in_valid&in_sof -> RUN, beat_cnt=1, inject {v=1,sof=1}.
  - IDLE: in_valid without in_sof -> beat ignored, no tag injected.
  - RUN: in_valid&!in_sof -> beat_cnt+1, inject v=1.
  - RUN, beat_cnt==NBEATS-1 -> inject eof; then IDLE, beat_cnt=0.
  - Back-to-back: an sof on the cycle after eof is accepted directly (IDLE is transparent for that cycle); zero bubble.
  - RUN & !in_valid (gap): inject abort tag, -> IDLE.
  - RUN & in_valid&in_sof before the last beat (early sof): inject abort tag in the same cycle, then treat the beat as a new sof (beat_cnt=1, stay RUN).
  - in_ready is always 1; the pipeline does not stall.
- Delay line: a 4-bit tag {v,sof,eof,abort} shifted every cycle. Length TOTAL_LAT = (NSTAGE+1)*BF_LAT + 2^NSTAGE - 1 (25 with defaults).
- Start offsets: stage_start[k] = injected sof delayed by OFF_k = (k+1)*BF_LAT + 2^k - 1 (2, 5, 9, 15 with defaults).
- Outputs: out_valid/out_sof/out_eof/out_abort = tag at tap TOTAL_LAT, registered outputs.
- frame_cnt: increments on out_eof; does not increment on out_abort.
- Done check: stage_done[k] must be high exactly 2 cycles after stage_start[k], and at no other time. Any violation sets sync_err on the next cycle; sync_err holds until reset.
- Simultaneous events:
  - Overlapping frames' start pulses at different stages are independent.
  - An abort tag and a new sof in the same injection cycle both propagate; abort is on the same tag as the new sof.
- Arithmetic: beat_cnt width clog2(NBEATS); compare against NBEATS-1; no wrap beyond that.

Decomposition:
- Shared package/header: clog2 function; TOTAL_LAT and OFF_k derivation functions; tag bit index constants (TAG_V, TAG_SOF, TAG_EOF, TAG_ABORT).
- One natural sub-module: seq_tag_delay (parameterised-length shift register of 4-bit tags with NSTAGE sof taps).
- Done checking is NSTAGE instances of a 2-deep shift compare inside the top level.

Test Plan:
- Single frame: sof at cycle 10, 16 contiguous beats ->
  - stage_start[0..3] pulses at cycles 12, 15, 19, 25.
  - out_valid cycles 35..50; out_sof @35, out_eof @50; frame_cnt=1.
- Back-to-back frames: 3 frames, no gaps -> out_valid continuous for 48 cycles; out_sof @35, 51, 67; frame_cnt=3; no out_abort.
- Gap abort: sof @10, in_valid low @15 ->
  - out_abort pulse @40; no out_eof for that frame; frame_cnt unchanged.
  - Next sof @20 emerges normally @45.
- Early sof: sof @10, second sof @18 -> out_abort and out_sof both @43; second frame completes with out_eof @58.
- Done checker: tie stage_done[2] to stage_start[2] delayed 3 cycles -> sync_err rises on the cycle after the expected done and stays 1. A correct 2-cycle echo keeps sync_err at 0.
- Reset mid-frame: assert reset @20 during a frame -> next cycle all outputs 0 and in_ready=1; no out_valid/out_abort ever emerges for that frame; a new sof @30 gives out_sof @55.
